// File: rtl/rstn_gen_bit_sync.sv
// Parameterised single-bit synchronizer chain; STAGES=0 degenerates to a wire.
// All flops power up low so a downstream reset is held asserted out of configuration.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d_i,
  output logic q_o
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_clk;
      assign unused_clk = clk;
      assign q_o        = d_i;
    end else begin : g_ff
      logic [STAGES-1:0] sync_q = '0;

      always_ff @(posedge clk) begin
        sync_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end

      assign q_o = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/rstn_gen.sv
// Reset generator / debouncer: o_rstn rises after TICK consecutive high samples of the
// synchronized input and drops SYNC_STAGES edges after any low sample.
module rstn_gen #(
  parameter int TICK        = 5_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_rstn,
  output logic o_rstn
);

  localparam int CNT_W = $clog2(longint'(TICK) + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK - 1);

  generate
    if (TICK < 1) begin : g_bad_tick
      $error("rstn_gen: TICK must be at least 1");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("rstn_gen: SYNC_STAGES must be in 0..4");
    end
  endgenerate

  logic             rstn_s;
  logic [CNT_W-1:0] cnt_q  = '0;
  logic [CNT_W-1:0] cnt_d;
  logic             rstn_q = 1'b0;
  logic             rstn_d;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .d_i (i_rstn),
    .q_o (rstn_s)
  );

  // Any low sample restarts the count; once asserted the counter saturates and never wraps.
  always_comb begin
    cnt_d  = cnt_q;
    rstn_d = rstn_q;
    if (!rstn_s) begin
      cnt_d  = '0;
      rstn_d = 1'b0;
    end else if (cnt_q == CNT_LAST || rstn_q) begin
      rstn_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    rstn_q <= rstn_d;
  end

  assign o_rstn = rstn_q;

endmodule

// File: tb/tb_rstn_gen.sv
// Bench for rstn_gen: two instances (TICK=5/SYNC=2 and TICK=1/SYNC=0) driven from
// directed segment tables; expected outputs are queued and checked by separate monitors.
module tb_rstn_gen;

  typedef struct {
    bit in_v;
    int n;
    bit exp_v;
  } seg_t;

  logic clk = 1'b0;
  logic a_rstn = 1'b0;
  logic b_rstn = 1'b0;
  logic a_out;
  logic b_out;

  bit   exp_a_q[$];
  bit   exp_b_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   a_done = 1'b0;
  bit   b_done = 1'b0;

  always #5 clk = ~clk;

  rstn_gen #(
    .TICK       (5),
    .SYNC_STAGES(2)
  ) dut_a (
    .clk    (clk),
    .i_rstn (a_rstn),
    .o_rstn (a_out)
  );

  rstn_gen #(
    .TICK       (1),
    .SYNC_STAGES(0)
  ) dut_b (
    .clk    (clk),
    .i_rstn (b_rstn),
    .o_rstn (b_out)
  );

  // Each segment: input level held for n edges, and o_rstn expected after each of those edges.
  seg_t segs_a[$] = '{
    '{1'b0, 10, 1'b0},   // power-up held in reset
    '{1'b1, 6, 1'b0},    // edges 0..5 after first high sample
    '{1'b1, 101, 1'b1},  // rises after edge 6, then holds
    '{1'b0, 1, 1'b1},    // one-cycle drop at edge M: still high after M
    '{1'b1, 1, 1'b1},    // still high after M+1
    '{1'b1, 5, 1'b0},    // low after M+2 .. M+6
    '{1'b1, 10, 1'b1},   // re-rises after M+7
    '{1'b0, 2, 1'b1},    // long low: two edges of sync latency
    '{1'b0, 5, 1'b0},
    '{1'b1, 4, 1'b0},    // bounce: 4 high samples
    '{1'b0, 1, 1'b0},    // single low sample kills the count at TICK-1
    '{1'b1, 6, 1'b0},    // full restart from the final rise
    '{1'b1, 5, 1'b1}
  };

  seg_t segs_b[$] = '{
    '{1'b0, 3, 1'b0},
    '{1'b1, 1, 1'b1},    // TICK=1, no sync: rises on the first high edge
    '{1'b1, 3, 1'b1},
    '{1'b0, 1, 1'b0},    // falls on the low edge itself
    '{1'b1, 1, 1'b1},
    '{1'b0, 2, 1'b0}
  };

  initial begin : stim_a
    foreach (segs_a[s]) begin
      for (int k = 0; k < segs_a[s].n; k++) begin
        @(negedge clk);
        a_rstn = segs_a[s].in_v;
        exp_a_q.push_back(segs_a[s].exp_v);
      end
    end
    a_done = 1'b1;
  end

  initial begin : stim_b
    foreach (segs_b[s]) begin
      for (int k = 0; k < segs_b[s].n; k++) begin
        @(negedge clk);
        b_rstn = segs_b[s].in_v;
        exp_b_q.push_back(segs_b[s].exp_v);
      end
    end
    b_done = 1'b1;
  end

  always @(posedge clk) begin : mon
    bit e;
    #1;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      n_cmp++;
      if (a_out !== e) begin
        n_err++;
        $display("FAIL a_o_rstn t=%0t got=%b want=%b", $time, a_out, e);
      end
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      n_cmp++;
      if (b_out !== e) begin
        n_err++;
        $display("FAIL b_o_rstn t=%0t got=%b want=%b", $time, b_out, e);
      end
    end
  end

  initial begin : ctrl
    int budget;
    budget = 0;
    while (!(a_done && b_done) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (!(a_done && b_done) || exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending_a=%0d pending_b=%0d want=0", exp_a_q.size(), exp_b_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
